program_loader: RTL

//  Write-side counterpart to the processor's instruction fetch: streams a program

---
 rtl/program_loader.sv | 128 ++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Streams a byte-serial program into the 128x16 instruction memory, high byte first,
// holding the processor in reset until a load ends on the halt word.
module program_loader #(
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'h5000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              Abort,
  input  logic              In_Valid,
  input  logic [7:0]        In_Data,
  output logic              In_Ready,
  output logic              Mem_WrEn,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  output logic              Proc_Reset,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Word_Count
);

  typedef enum logic [1:0] {
    IDLE,
    GET_HI,
    GET_LO,
    WRITE
  } state_e;

  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W-1:0] AddrOne  = 1;
  localparam logic [ADDR_W:0]   CountOne = 1;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                procReset_q;
  logic                done_q;
  logic                error_q;
  logic [ADDR_W:0]     wordCount_q;

  logic [ADDR_W:0]     wordCount_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                accept;

  assign accept      = In_Valid & In_Ready;
  assign wordCount_d = wordCount_q + CountOne;
  assign addr_d      = addr_q + AddrOne;

  // Abort outranks every other exit; a WRITE strobe already on the bus still counts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      procReset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      wordCount_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start && !Abort) begin
            state_q     <= GET_HI;
            addr_q      <= '0;
            wordCount_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            procReset_q <= 1'b1;
          end
        end
        GET_HI: begin
          if (Abort) begin
            state_q     <= IDLE;
            error_q     <= 1'b1;
            procReset_q <= 1'b1;
          end else if (accept) begin
            data_q[DATA_W-1 -: 8] <= In_Data;
            state_q               <= GET_LO;
          end
        end
        GET_LO: begin
          if (Abort) begin
            state_q     <= IDLE;
            error_q     <= 1'b1;
            procReset_q <= 1'b1;
          end else if (accept) begin
            data_q[7:0] <= In_Data;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          wordCount_q <= wordCount_d;
          if (Abort) begin
            state_q     <= IDLE;
            error_q     <= 1'b1;
            procReset_q <= 1'b1;
          end else if (data_q == HALT_WORD) begin
            state_q     <= IDLE;
            done_q      <= 1'b1;
            procReset_q <= 1'b0;
          end else if (addr_q == LastAddr) begin
            // Memory full without a halt word: stop rather than wrap over word 0.
            state_q <= IDLE;
            error_q <= 1'b1;
          end else begin
            addr_q  <= addr_d;
            state_q <= GET_HI;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign In_Ready   = (state_q == GET_HI) || (state_q == GET_LO);
  assign Mem_WrEn   = (state_q == WRITE);
  assign Busy       = (state_q != IDLE);
  assign Mem_Addr   = addr_q;
  assign Mem_Data   = data_q;
  assign Proc_Reset = procReset_q;
  assign Done       = done_q;
  assign Error      = error_q;
  assign Word_Count = wordCount_q;

endmodule
